// File: rtl/fpu_arbiter.sv
// fpu_arbiter: round-robin arbiter sharing one FP add/sub unit between two requesters,
// with a watchdog that answers with a quiet NaN and an error flag if the unit never responds.
module fpu_arbiter #(
    parameter int WATCHDOG = 15
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req0_valid,
    input  logic        req0_op,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic        req1_valid,
    input  logic        req1_op,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    output logic        req0_grant,
    output logic        req0_done,
    output logic [31:0] req0_result,
    output logic        req0_err,
    output logic        req1_grant,
    output logic        req1_done,
    output logic [31:0] req1_result,
    output logic        req1_err,
    output logic        fpu_start,
    output logic        fpu_op,
    output logic [31:0] fpu_a,
    output logic [31:0] fpu_b,
    input  logic        fpu_busy,
    input  logic        fpu_ready,
    input  logic [31:0] fpu_data
);
    localparam int CW = $clog2(WATCHDOG + 1);
    localparam logic [31:0] QNAN = 32'h7FC00000;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

    state_e      state_q;
    logic        ptr_q, win_q, op_q, start_q, sel_d;
    logic [CW-1:0] cnt_q;
    logic [1:0]  grant_q, done_q, err_q;
    logic [31:0] res0_q, res1_q, a_q, b_q;
    logic        unused_busy;

    assign unused_busy = fpu_busy;
    assign sel_d = (req0_valid & req1_valid) ? ptr_q : req1_valid;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
            ptr_q   <= 1'b0;
            win_q   <= 1'b0;
            cnt_q   <= '0;
            grant_q <= '0;
            done_q  <= '0;
            err_q   <= '0;
            res0_q  <= '0;
            res1_q  <= '0;
            op_q    <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            start_q <= 1'b0;
        end else begin
            start_q <= 1'b0;
            grant_q <= '0;
            done_q  <= '0;
            case (state_q)
                IDLE: if (req0_valid | req1_valid) begin
                    win_q   <= sel_d;
                    op_q    <= sel_d ? req1_op : req0_op;
                    a_q     <= sel_d ? req1_a : req0_a;
                    b_q     <= sel_d ? req1_b : req0_b;
                    start_q <= 1'b1;
                    grant_q <= sel_d ? 2'b10 : 2'b01;
                    state_q <= ISSUE;
                end
                ISSUE: begin
                    cnt_q   <= '0;
                    state_q <= WAIT;
                end
                // a response landing on the expiry cycle still wins over the timeout
                WAIT: if (fpu_ready || cnt_q == CW'(WATCHDOG - 1)) begin
                    if (win_q) begin
                        res1_q   <= fpu_ready ? fpu_data : QNAN;
                        err_q[1] <= !fpu_ready;
                    end else begin
                        res0_q   <= fpu_ready ? fpu_data : QNAN;
                        err_q[0] <= !fpu_ready;
                    end
                    done_q  <= win_q ? 2'b10 : 2'b01;
                    state_q <= RESP;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
                RESP: begin
                    ptr_q   <= ~win_q;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req0_grant  = grant_q[0];
    assign req1_grant  = grant_q[1];
    assign req0_done   = done_q[0];
    assign req1_done   = done_q[1];
    assign req0_err    = err_q[0];
    assign req1_err    = err_q[1];
    assign req0_result = res0_q;
    assign req1_result = res1_q;
    assign fpu_start   = start_q;
    assign fpu_op      = op_q;
    assign fpu_a       = a_q;
    assign fpu_b       = b_q;
endmodule

// File: tb/tb_fpu_arbiter.sv
// tb_fpu_arbiter: directed plus randomized bench for fpu_arbiter, checked against a
// transaction/timestamp reference model and an emulated FP unit with controllable latency.
module tb_fpu_arbiter;
    localparam int W = 6;
    localparam logic [31:0] QNAN = 32'h7FC00000;

    logic        clock = 1'b0, reset = 1'b0;
    logic        req0_valid = 1'b0, req0_op = 1'b0, req1_valid = 1'b0, req1_op = 1'b0;
    logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic        req0_grant, req0_done, req0_err, req1_grant, req1_done, req1_err;
    logic [31:0] req0_result, req1_result;
    logic        fpu_start, fpu_op;
    logic [31:0] fpu_a, fpu_b;
    logic        fpu_busy = 1'b0, fpu_ready = 1'b0;
    logic [31:0] fpu_data = '0;

    fpu_arbiter #(.WATCHDOG(W)) dut (
        .clock(clock), .reset(reset),
        .req0_valid(req0_valid), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
        .req0_grant(req0_grant), .req0_done(req0_done), .req0_result(req0_result), .req0_err(req0_err),
        .req1_grant(req1_grant), .req1_done(req1_done), .req1_result(req1_result), .req1_err(req1_err),
        .fpu_start(fpu_start), .fpu_op(fpu_op), .fpu_a(fpu_a), .fpu_b(fpu_b),
        .fpu_busy(fpu_busy), .fpu_ready(fpu_ready), .fpu_data(fpu_data)
    );

    always #5 clock = ~clock;

    int compared = 0, mismatched = 0, cyc = 0;
    int lat = 1, rdy_at = -1, stray_at = -1, last_start = -1, last_done = -1, last_grant = -1;
    logic [31:0] rdy_dat = '0;
    int g_hist[$];

    bit          m_busy = 0, m_win = 0, m_ptr = 0, m_op = 0;
    int          m_t0 = 0, m_dc = -1;
    logic [31:0] m_res0 = '0, m_res1 = '0, m_a = '0, m_b = '0;
    logic [1:0]  m_err = '0;

    function automatic logic [31:0] fpu_fn(input logic op, input logic [31:0] a, input logic [31:0] b);
        if (!op && a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
        if (op && a == 32'h40A00000 && b == 32'h3F800000) return 32'h40800000;
        return {a[31:16] ^ b[15:0], a[15:0] + b[31:16]} ^ {31'd0, op};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic cv0, cv1, cop0, cop1, crdy, crst;
        logic [31:0] ca0, cb0, ca1, cb1, cdat, r;
        logic [1:0] eg, ed;
        logic es;
        int k;
        cv0 = req0_valid; cv1 = req1_valid; cop0 = req0_op; cop1 = req1_op;
        ca0 = req0_a; cb0 = req0_b; ca1 = req1_a; cb1 = req1_b;
        crdy = fpu_ready; cdat = fpu_data; crst = reset;
        @(posedge clock);
        #1;
        cyc++;
        eg = '0; ed = '0; es = 1'b0;
        if (!crst) begin
            m_busy = 0; m_ptr = 0; m_op = 0; m_a = '0; m_b = '0;
            m_res0 = '0; m_res1 = '0; m_err = '0;
        end else if (m_busy) begin
            if (m_dc >= 0) begin
                if (cyc == m_dc + 1) begin m_busy = 0; m_ptr = !m_win; end
            end else if (cyc >= m_t0 + 2) begin
                k = cyc - m_t0 - 2;
                if (crdy || k == W - 1) begin
                    r = crdy ? cdat : QNAN;
                    if (m_win) begin m_res1 = r; m_err[1] = !crdy; end
                    else begin m_res0 = r; m_err[0] = !crdy; end
                    ed[m_win] = 1'b1;
                    m_dc = cyc;
                end
            end
        end else if (cv0 | cv1) begin
            m_win = (cv0 && cv1) ? m_ptr : cv1;
            m_op = m_win ? cop1 : cop0;
            m_a = m_win ? ca1 : ca0;
            m_b = m_win ? cb1 : cb0;
            m_busy = 1; m_t0 = cyc; m_dc = -1;
            eg[m_win] = 1'b1; es = 1'b1;
        end
        chk("pulses", 128'({req0_grant, req1_grant, req0_done, req1_done, fpu_start}),
            128'({eg[0], eg[1], ed[0], ed[1], es}));
        chk("results", 128'({req0_result, req1_result, req0_err, req1_err}), 128'({m_res0, m_res1, m_err[0], m_err[1]}));
        chk("operands", 128'({fpu_op, fpu_a, fpu_b}), 128'({m_op, m_a, m_b}));
        chk("exclusive", 128'({req0_grant & req1_grant, req0_done & req1_done}), 128'(0));
        if (req0_grant) begin g_hist.push_back(0); last_grant = cyc; end
        if (req1_grant) begin g_hist.push_back(1); last_grant = cyc; end
        if (req0_done | req1_done) last_done = cyc;
        if (fpu_start) begin
            last_start = cyc;
            rdy_at = (lat == 0) ? -1 : cyc + lat;
            rdy_dat = fpu_fn(fpu_op, fpu_a, fpu_b);
        end
        fpu_ready = (cyc == rdy_at) || (cyc == stray_at);
        fpu_data = (cyc == rdy_at) ? rdy_dat : (fpu_ready ? 32'hDEADBEEF : $urandom);
        fpu_busy = (rdy_at > cyc);
    endtask

    task automatic serve(input bit w0, input bit w1);
        bit s0, s1, got;
        s0 = !w0; s1 = !w1; got = 0;
        for (int n = 0; n < 80 && !got; n++) begin
            tick();
            if (req0_grant) req0_valid = 1'b0;
            if (req1_grant) req1_valid = 1'b0;
            if (req0_done) s0 = 1;
            if (req1_done) s1 = 1;
            got = s0 && s1;
        end
        chk("serve_done_seen", 128'(got), 128'(1));
    endtask

    task automatic rand_req1();
        req1_op = 1'($urandom); req1_a = $urandom; req1_b = $urandom; req1_valid = 1'b1;
    endtask

    initial begin
        int dones;
        tick(); tick();
        chk("reset_ctrl", 128'({req0_grant, req1_grant, req0_done, req1_done, req0_err, req1_err, fpu_start, fpu_op}), 128'(0));
        chk("reset_data", {req0_result, req1_result, fpu_a, fpu_b}, 128'(0));
        reset = 1'b1;
        tick();

        // single add
        lat = 1;
        req0_op = 1'b0; req0_a = 32'h3F800000; req0_b = 32'h40000000; req0_valid = 1'b1;
        serve(1, 0);
        chk("add_grant_with_start", 128'(last_grant), 128'(last_start));
        chk("add_ready_to_done", 128'(last_done - last_start), 128'(2));
        chk("add_result", 128'({req0_result, req0_err}), 128'({32'h40400000, 1'b0}));
        repeat (3) tick();

        // contention right after reset, then fairness with both held valid
        reset = 1'b0; tick(); reset = 1'b1;
        req1_op = 1'b1; req1_a = 32'h40A00000; req1_b = 32'h3F800000;
        req0_valid = 1'b1; req1_valid = 1'b1;
        g_hist.delete();
        serve(1, 1);
        chk("contention_order", 128'({g_hist.size(), g_hist[0], g_hist[1]}), 128'({32'd2, 32'd0, 32'd1}));
        chk("contention_result1", 128'({req1_result, req1_err}), 128'({32'h40800000, 1'b0}));
        chk("contention_result0", 128'(req0_result), 128'(32'h40400000));
        g_hist.delete();
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int n = 0; n < 300 && g_hist.size() < 6; n++) tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (8) tick();
        chk("fairness_count", 128'(g_hist.size()), 128'(6));
        for (int i = 0; i < 6 && i < g_hist.size(); i++) chk("fairness_alt", 128'(g_hist[i]), 128'(i % 2));

        // watchdog expiry
        lat = 0;
        req0_op = 1'b1; req0_a = 32'h12345678; req0_b = 32'h9ABCDEF0; req0_valid = 1'b1;
        serve(1, 0);
        chk("wd_latency", 128'(last_done - last_start), 128'(W + 1));
        chk("wd_result", 128'({req0_result, req0_err}), 128'({QNAN, 1'b1}));
        tick(); tick();

        // ready on the expiry cycle wins
        lat = W;
        rand_req1();
        serve(0, 1);
        chk("coincide_latency", 128'(last_done - last_start), 128'(W + 1));
        chk("coincide_result", 128'({req1_result, req1_err}), 128'({fpu_fn(fpu_op, fpu_a, fpu_b), 1'b0}));
        tick(); tick();

        // stray ready while idle
        stray_at = cyc + 1;
        dones = 0;
        repeat (4) begin tick(); dones += int'(req0_done) + int'(req1_done); end
        chk("stray_no_done", 128'(dones), 128'(0));
        chk("stray_result_kept", 128'({req0_result, req0_err}), 128'({QNAN, 1'b1}));

        // reset in the middle of WAIT, late ready must be ignored
        lat = W;
        req0_op = 1'b0; req0_a = 32'h11111111; req0_b = 32'h22222222; req0_valid = 1'b1;
        for (int n = 0; n < 10 && !req0_grant; n++) tick();
        chk("midwait_granted", 128'(req0_grant), 128'(1));
        req0_valid = 1'b0;
        tick(); tick();
        reset = 1'b0; tick(); reset = 1'b1;
        chk("midwait_ctrl_zero", 128'({req0_grant, req1_grant, req0_done, req1_done, req0_err, req1_err, fpu_start, fpu_op}), 128'(0));
        chk("midwait_data_zero", {req0_result, req1_result, fpu_a, fpu_b}, 128'(0));
        dones = 0;
        repeat (W + 3) begin tick(); dones += int'(req0_done) + int'(req1_done); end
        chk("midwait_no_done", 128'(dones), 128'(0));
        lat = 2;
        rand_req1();
        serve(0, 1);
        chk("after_reset_latency", 128'(last_done - last_start), 128'(3));
        chk("after_reset_result", 128'({req1_result, req1_err}), 128'({fpu_fn(fpu_op, fpu_a, fpu_b), 1'b0}));

        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            if (!req0_valid && $urandom_range(3) == 0) begin
                req0_valid = 1'b1; req0_op = 1'($urandom); req0_a = $urandom; req0_b = $urandom;
            end
            if (!req1_valid && $urandom_range(3) == 0) rand_req1();
            lat = ($urandom_range(7) == 0) ? 0 : int'($urandom_range(W + 2, 1));
            if ($urandom_range(150) == 0) stray_at = cyc + 1;
            reset = ($urandom_range(300) != 0);
            tick();
            if (req0_grant) begin
                req0_valid = ($urandom_range(2) == 0); req0_op = 1'($urandom); req0_a = $urandom; req0_b = $urandom;
            end
            if (req1_grant) begin
                req1_valid = ($urandom_range(2) == 0); req1_op = 1'($urandom); req1_a = $urandom; req1_b = $urandom;
            end
        end
        reset = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (W + 6) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
